sync_buffer: RTL and testbench

Single-clock, parametrised FIFO buffer between a 16-bit producer (Fibonacci or Timer module) and a consumer running in the same clock domain. It generalises width and depth, uses all DEPTH entries (no sacrificed slot), and adds an occupancy count, programmable almost-full/almost-empty thresholds and a registered read port with a valid strobe. Optional sticky error flags report writes into a full buffer and reads from an empty one.

---
 rtl/buffer_pkg.sv | 22 ++
 rtl/sync_buffer_mem.sv | 33 +++
 rtl/sync_buffer.sv | 113 +++++++++++
 tb/tb_sync_buffer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared constants and width helpers for sync_buffer
package buffer_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_DEPTH  = 8;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Pointer/count width: address bits plus one wrap bit.
  function automatic int unsigned cw_of(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  localparam int unsigned DEF_CW = cw_of(DEF_DEPTH);

endpackage

// File: rtl/sync_buffer_mem.sv
// rtl/sync_buffer_mem.sv - DEPTH x DATA_W storage, one write port, one registered read port
module sync_buffer_mem
  import buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage write; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Synchronous read; output holds its value while no read is requested.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_buffer.sv
// rtl/sync_buffer.sv - single-clock FIFO with count, thresholds, registered read; SYNC_BUFFER_ERR_EN adds sticky overflow/underflow
module sync_buffer
  import buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AFULL_TH  = 6,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned AW       = clog2(DEPTH),
  localparam int unsigned CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rd_valid_q;
  logic              rd_seen_q;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Flags come only from registered pointers, so they reflect pre-edge state.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Next-state pointers and occupancy; wrap is plain modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
    count_d = wr_ptr_d - rd_ptr_d;
  end

  // Pointer, count and read-strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_seen_q <= 1'b1;
    end
  end

  sync_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (mem_rdata)
  );

  // The storage read register has no reset, so mask it to zero until the
  // first accepted read after reset reloads it.
  assign rd_data      = rd_seen_q ? mem_rdata : '0;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign almost_full  = (count_q >= CW'(AFULL_TH));

`ifdef SYNC_BUFFER_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full)  overflow_q  <= 1'b1;
      if (rd_en && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_buffer.sv
// tb/tb_sync_buffer.sv - directed scoreboard bench for sync_buffer
module tb_sync_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;
`ifdef SYNC_BUFFER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [3:0]    count;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic          overflow;
  logic          underflow;

  sync_buffer #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_pass = 0;
  int            n_total = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] last_rd;
  int            exp_count;
  bit            ovf_m;
  bit            udf_m;
  string         phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s %s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
  endtask

  task automatic check_status();
    check("count", 32'(count), 32'(exp_count));
    check("empty", 32'(empty), 32'(exp_count == 0));
    check("full", 32'(full), 32'(exp_count == DEPTH));
    check("almost_empty", 32'(almost_empty), 32'(exp_count <= AE_TH));
    check("almost_full", 32'(almost_full), 32'(exp_count >= AF_TH));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("underflow", 32'(underflow), 32'(udf_m));
  endtask

  task automatic model_reset();
    sb_q.delete();
    last_rd   = '0;
    exp_count = 0;
    ovf_m     = 1'b0;
    udf_m     = 1'b0;
  endtask

  // One clock of stimulus; the scoreboard decides acceptance from pre-edge occupancy.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    bit acc_w;
    bit acc_r;
    int sz;
    sz    = sb_q.size();
    acc_w = w && (sz < DEPTH);
    acc_r = r && (sz > 0);
    if (ERR_EN && w && (sz == DEPTH)) ovf_m = 1'b1;
    if (ERR_EN && r && (sz == 0)) udf_m = 1'b1;
    exp_count = sz + int'(acc_w) - int'(acc_r);
    if (acc_w) sb_q.push_back(d);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'(acc_r));
    if (acc_r) last_rd = sb_q.pop_front();
    check("rd_data", 32'(rd_data), 32'(last_rd));
    check_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] v;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    rst_n   = 1'b0;
    model_reset();
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check("rd_valid", 32'(rd_valid), 32'd0);
    check("rd_data", 32'(rd_data), 32'd0);
    check_status();
    rst_n = 1'b1;

    phase = "fill";
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 16'h0009, 1'b0);

    phase = "drain";
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    phase = "wrap";
    v = 16'h0100;
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b1, v, 1'b0);
        v = v + 16'd1;
      end
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    end

    phase = "simul";
    v = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, v, 1'b0);
      v = v + 16'd1;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, v, 1'b1);
      v = v + 16'd1;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, v, 1'b0);
      v = v + 16'd1;
    end
    phase = "simul_full";
    step(1'b1, 16'hdead, 1'b1);
    phase = "simul_drain";
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    phase = "simul_empty";
    step(1'b1, 16'h0abc, 1'b1);
    step(1'b0, '0, 1'b1);

    phase = "midreset";
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + DW'(i), 1'b0);
    rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rd_valid", 32'(rd_valid), 32'd0);
    check("rd_data", 32'(rd_data), 32'd0);
    check_status();
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    phase = "post_reset";
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0400 + DW'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
